// File: rtl/accel_seq.sv
// Accelerometer transaction sequencer: WHO_AM_I check, two config writes, then
// periodic six-byte output reads presented as X/Y/Z samples to the SPI master.
module accel_seq #(
  parameter int         POLL_DIV  = 1000,
  parameter logic [7:0] ID_ADDR   = 8'h0F,
  parameter logic [7:0] ID_VAL    = 8'h33,
  parameter logic [7:0] CFG1_ADDR = 8'h20,
  parameter logic [7:0] CFG1_VAL  = 8'h57,
  parameter logic [7:0] CFG2_ADDR = 8'h23,
  parameter logic [7:0] CFG2_VAL  = 8'h08,
  parameter logic [7:0] OUT_BASE  = 8'h28
) (
  input  logic        clk,
  input  logic        reset,
  output logic [7:0]  spi_addr,
  output logic [7:0]  spi_wdata,
  output logic        spi_read,
  output logic        spi_enable,
  input  logic [7:0]  spi_rdata,
  input  logic        spi_done,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic        sample_valid,
  output logic        init_done,
  output logic        id_error
);

  // state     | meaning
  // IDLE      | first cycle after reset
  // ID_REQ    | launch WHO_AM_I read
  // ID_WAIT   | wait for WHO_AM_I data, compare
  // CFG1_REQ  | launch first config write
  // CFG1_WAIT | wait for first config write
  // CFG2_REQ  | launch second config write
  // CFG2_WAIT | wait for second config write
  // POLL      | idle gap between sample rounds
  // RD_REQ    | launch output byte read [idx]
  // RD_WAIT   | wait for output byte [idx]
  // ERROR     | WHO_AM_I mismatch, parked until reset
  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ID_REQ    = 4'd1;
  localparam logic [3:0] S_ID_WAIT   = 4'd2;
  localparam logic [3:0] S_CFG1_REQ  = 4'd3;
  localparam logic [3:0] S_CFG1_WAIT = 4'd4;
  localparam logic [3:0] S_CFG2_REQ  = 4'd5;
  localparam logic [3:0] S_CFG2_WAIT = 4'd6;
  localparam logic [3:0] S_POLL      = 4'd7;
  localparam logic [3:0] S_RD_REQ    = 4'd8;
  localparam logic [3:0] S_RD_WAIT   = 4'd9;
  localparam logic [3:0] S_ERROR     = 4'd10;

  localparam int            CW        = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [CW-1:0] POLL_LAST = CW'(POLL_DIV - 1);

  logic [3:0]    state;
  logic [CW-1:0] poll_cnt;
  logic [2:0]    idx;
  // Byte 5 (Z_H) goes straight from spi_rdata into accel_z, so only 0..4 are buffered.
  logic [7:0]    buffer [0:4];

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      poll_cnt     <= '0;
      idx          <= '0;
      init_done    <= 1'b0;
      id_error     <= 1'b0;
      sample_valid <= 1'b0;
      accel_x      <= '0;
      accel_y      <= '0;
      accel_z      <= '0;
      for (int i = 0; i < 5; i++) buffer[i] <= '0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        S_IDLE:     state <= S_ID_REQ;
        S_ID_REQ:   state <= S_ID_WAIT;
        S_ID_WAIT:
          if (spi_done) begin
            if (spi_rdata == ID_VAL) begin
              state <= S_CFG1_REQ;
            end else begin
              state    <= S_ERROR;
              id_error <= 1'b1;
            end
          end
        S_CFG1_REQ:  state <= S_CFG1_WAIT;
        S_CFG1_WAIT: if (spi_done) state <= S_CFG2_REQ;
        S_CFG2_REQ:  state <= S_CFG2_WAIT;
        S_CFG2_WAIT:
          if (spi_done) begin
            init_done <= 1'b1;
            poll_cnt  <= '0;
            state     <= S_POLL;
          end
        S_POLL:
          if (poll_cnt == POLL_LAST) begin
            poll_cnt <= '0;
            idx      <= '0;
            state    <= S_RD_REQ;
          end else begin
            poll_cnt <= poll_cnt + 1'b1;
          end
        S_RD_REQ: state <= S_RD_WAIT;
        S_RD_WAIT:
          if (spi_done) begin
            if (idx == 3'd5) begin
              // All three axes load on the same edge so no partial sample is visible.
              accel_x      <= {buffer[1], buffer[0]};
              accel_y      <= {buffer[3], buffer[2]};
              accel_z      <= {spi_rdata, buffer[4]};
              sample_valid <= 1'b1;
              state        <= S_POLL;
            end else begin
              buffer[idx] <= spi_rdata;
              idx         <= idx + 3'd1;
              state       <= S_RD_REQ;
            end
          end
        S_ERROR: state <= S_ERROR;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Transaction fields are decoded from state so they stay fixed through each WAIT.
  always_comb begin
    spi_addr   = 8'h00;
    spi_wdata  = 8'h00;
    spi_read   = 1'b0;
    spi_enable = 1'b0;
    case (state)
      S_ID_REQ, S_ID_WAIT: begin
        spi_addr = ID_ADDR;
        spi_read = 1'b1;
      end
      S_CFG1_REQ, S_CFG1_WAIT: begin
        spi_addr  = CFG1_ADDR;
        spi_wdata = CFG1_VAL;
      end
      S_CFG2_REQ, S_CFG2_WAIT: begin
        spi_addr  = CFG2_ADDR;
        spi_wdata = CFG2_VAL;
      end
      S_RD_REQ, S_RD_WAIT: begin
        spi_addr = OUT_BASE + {5'b00000, idx};
        spi_read = 1'b1;
      end
      default: ;
    endcase
    spi_enable = (state == S_ID_REQ) || (state == S_CFG1_REQ) ||
                 (state == S_CFG2_REQ) || (state == S_RD_REQ);
  end

endmodule

// File: tb/tb_accel_seq.sv
// Directed bench for accel_seq: a behavioural SPI master answers each request
// 34 cycles after its enable; outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_accel_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  spi_addr, spi_wdata, spi_rdata;
  logic        spi_read, spi_enable, spi_done;
  logic [15:0] accel_x, accel_y, accel_z;
  logic        sample_valid, init_done, id_error;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  accel_seq #(.POLL_DIV(10)) dut (
    .clk(clk), .reset(reset),
    .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_read(spi_read),
    .spi_enable(spi_enable), .spi_rdata(spi_rdata), .spi_done(spi_done),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
    .sample_valid(sample_valid), .init_done(init_done), .id_error(id_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a request, checks its fields, holds for the transfer, then answers.
  task automatic serve(input string tag, input logic [7:0] a, input logic r,
                       input logic [7:0] wd, input logic [7:0] rd, output int waited);
    logic stable;
    waited = 0;
    while (!spi_enable && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_en"}, {31'd0, spi_enable}, 32'd1);
    if (!spi_enable) return;
    chk({tag, "_addr"}, {24'd0, spi_addr}, {24'd0, a});
    chk({tag, "_read"}, {31'd0, spi_read}, {31'd0, r});
    chk({tag, "_wdata"}, {24'd0, spi_wdata}, {24'd0, wd});
    stable = 1'b1;
    repeat (33) begin
      @(negedge clk);
      if (spi_enable || spi_addr != a || spi_read != r || spi_wdata != wd) stable = 1'b0;
    end
    chk({tag, "_hold"}, {31'd0, stable}, 32'd1);
    @(negedge clk);
    spi_done  = 1'b1;
    spi_rdata = rd;
    @(negedge clk);
    spi_done  = 1'b0;
    spi_rdata = 8'h00;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_en"}, {31'd0, spi_enable}, 32'd0);
    chk({tag, "_addr"}, {24'd0, spi_addr}, 32'd0);
    chk({tag, "_flags"}, {29'd0, sample_valid, init_done, id_error}, 32'd0);
    chk({tag, "_x"}, {16'd0, accel_x}, 32'd0);
    chk({tag, "_y"}, {16'd0, accel_y}, 32'd0);
    chk({tag, "_z"}, {16'd0, accel_z}, 32'd0);
  endtask

  initial begin
    int     w;
    int     en_cnt;
    longint t1, t2;
    logic [7:0] r1 [0:5];
    logic [7:0] r2 [0:5];
    r1 = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h00, 8'h80};
    r2 = '{8'h01, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h7F};

    reset = 1'b1; spi_done = 1'b0; spi_rdata = 8'h00;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    reset = 1'b0;

    // Nominal init
    serve("id", 8'h0F, 1'b1, 8'h00, 8'h33, w);
    chk("id_no_init", {31'd0, init_done}, 32'd0);
    serve("cfg1", 8'h20, 1'b0, 8'h57, 8'h00, w);
    chk("cfg1_gap", w, 0);
    serve("cfg2", 8'h23, 1'b0, 8'h08, 8'h00, w);
    chk("init_done", {31'd0, init_done}, 32'd1);
    chk("id_error0", {31'd0, id_error}, 32'd0);

    // First sample round; POLL lasts 10 cycles
    for (int i = 0; i < 6; i++) begin
      serve($sformatf("r1_%0d", i), 8'h28 + 8'(i), 1'b1, 8'h00, r1[i], w);
      if (i == 0) chk("poll_len", w, 10);
      else if (i < 5) chk("rd_x", {31'd0, sample_valid}, 32'd0);
    end
    t1 = $time;
    chk("sv1", {31'd0, sample_valid}, 32'd1);
    chk("x1", {16'd0, accel_x}, 32'h1234);
    chk("y1", {16'd0, accel_y}, 32'hABCD);
    chk("z1", {16'd0, accel_z}, 32'h8000);

    // Spurious done during POLL is ignored
    @(negedge clk);
    chk("sv1_pulse", {31'd0, sample_valid}, 32'd0);
    spi_done = 1'b1; spi_rdata = 8'hEE;
    @(negedge clk);
    spi_done = 1'b0; spi_rdata = 8'h00;
    chk("x_hold", {16'd0, accel_x}, 32'h1234);
    serve("r2_0", 8'h28, 1'b1, 8'h00, r2[0], w);
    chk("poll_len2", w, 8);
    for (int i = 1; i < 6; i++) begin
      serve($sformatf("r2_%0d", i), 8'h28 + 8'(i), 1'b1, 8'h00, r2[i], w);
      if (i < 5) chk("z_hold", {16'd0, accel_z}, 32'h8000);
    end
    t2 = $time;
    chk("sv2", {31'd0, sample_valid}, 32'd1);
    chk("period", 32'((t2 - t1) / 10), 32'd220);
    chk("x2", {16'd0, accel_x}, 32'h0001);
    chk("y2", {16'd0, accel_y}, 32'hFFFF);
    chk("z2", {16'd0, accel_z}, 32'h7F00);

    // Reset during third RD_WAIT
    serve("r3_0", 8'h28, 1'b1, 8'h00, 8'h55, w);
    serve("r3_1", 8'h29, 1'b1, 8'h00, 8'h66, w);
    w = 0;
    while (!spi_enable && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("r3_2_addr", {24'd0, spi_addr}, 32'h2A);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    reset = 1'b0;

    // ID mismatch after restart
    serve("id2", 8'h0F, 1'b1, 8'h00, 8'h32, w);
    chk("id_error1", {31'd0, id_error}, 32'd1);
    en_cnt = 0;
    repeat (2000) begin
      @(negedge clk);
      if (spi_enable) en_cnt++;
    end
    chk("err_no_en", en_cnt, 0);
    chk("err_init", {31'd0, init_done}, 32'd0);
    chk("err_sticky", {31'd0, id_error}, 32'd1);
    chk("err_x", {16'd0, accel_x}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/accel_seq.md
Name: accel_seq

Overview:
Transaction sequencer that sits directly upstream of the SPI master and drives its addr/wdata/read/enable inputs. After reset it checks the accelerometer WHO_AM_I register and writes two configuration registers. It then periodically reads the six output bytes (X/Y/Z, low/high) and presents them as three 16-bit samples with a one-cycle valid strobe.

Parameters:
POLL_DIV, 1000, idle cycles between sample rounds (minimum 1)
ID_ADDR, 8'h0F, WHO_AM_I register address
ID_VAL, 8'h33, expected WHO_AM_I value
CFG1_ADDR, 8'h20, first config register address
CFG1_VAL, 8'h57, first config write data
CFG2_ADDR, 8'h23, second config register address
CFG2_VAL, 8'h08, second config write data
OUT_BASE, 8'h28, address of X_L; bytes X_L,X_H,Y_L,Y_H,Z_L,Z_H are at OUT_BASE+0..5

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
spi_addr  out  8  register address to SPI master
spi_wdata  out  8  write data to SPI master
spi_read  out  1  1=read, 0=write
spi_enable  out  1  one-cycle transaction start pulse
spi_rdata  in  8  read data from SPI master, valid when spi_done=1
spi_done  in  1  one-cycle transaction-complete pulse
accel_x  out  16  {X_H,X_L}, two's complement
accel_y  out  16  {Y_H,Y_L}
accel_z  out  16  {Z_H,Z_L}
sample_valid  out  1  one-cycle pulse when accel_x/y/z update
init_done  out  1  high once configuration completes; stays high until reset
id_error  out  1  sticky; WHO_AM_I mismatch

Behaviour:
- Reset: all outputs 0, state IDLE, poll counter 0, byte index 0. The SPI master shares the same reset.
- States: IDLE -> ID_REQ -> ID_WAIT -> CFG1_REQ -> CFG1_WAIT -> CFG2_REQ -> CFG2_WAIT -> POLL -> RD_REQ -> RD_WAIT -> (RD_REQ | POLL). Also ERROR.
- IDLE: unconditional move to ID_REQ on the next cycle.
- *_REQ states:
  - spi_enable=1 for exactly that one cycle.
  - spi_addr, spi_wdata and spi_read are driven with the transaction's values.
  - Next state is the matching *_WAIT.
- *_WAIT states:
  - spi_enable=0; spi_addr, spi_wdata and spi_read are held stable, because the SPI master samples them throughout the transfer.
  - The state is left only on spi_done.
- Read transactions: spi_read=1 and spi_wdata=0.
- Write transactions: spi_read=0 and spi_wdata=CFGx_VAL.
- ID_WAIT on spi_done:
  - spi_rdata==ID_VAL: go to CFG1_REQ.
  - Otherwise: go to ERROR and set id_error=1.
  - ERROR is terminal until reset, with spi_enable=0 and no further transactions.
- CFG2_WAIT on spi_done: set init_done=1, clear the poll counter, go to POLL.
- POLL: the counter increments each cycle. When it equals POLL_DIV-1, the counter clears, the byte index is set to 0, and the state moves to RD_REQ. POLL therefore lasts exactly POLL_DIV cycles.
- RD_REQ: spi_addr=OUT_BASE+index (8-bit wrap).
- RD_WAIT on spi_done:
  - spi_rdata is stored in byte buffer[index].
  - If index<5: index increments and the state moves to RD_REQ.
  - If index==5: go to POLL.
- Sample update:
  - On the cycle after the index-5 done, accel_x/y/z are updated together from the buffer and sample_valid=1 for one cycle.
  - Outputs never show a partially updated sample.
  - accel_* hold their values between updates.
- Timing:
  - The next REQ begins the cycle after the done cycle, and the SPI master is idle then.
  - The SPI master needs 35 cycles per transaction (enable to done inclusive: 34 cycles later).
  - One read round is therefore 6×35=210 cycles; sample period = POLL_DIV+210 cycles.
- spi_done outside a *_WAIT state is ignored. spi_rdata is captured only on spi_done in a read WAIT state.
- Reset asserted mid-transaction: immediate return to reset values next cycle. The sequence restarts from ID_REQ, and init_done and id_error are cleared.

Test Plan:
- Nominal init: SPI model returns 8'h33 on the 0x0F read -> observe, in order, read 0x0F, write 0x20/0x57, write 0x23/0x08; init_done rises the cycle after the second write's done; id_error=0.
- ID mismatch: model returns 8'h32 -> id_error=1 the cycle after done; no spi_enable for 2000 cycles; init_done stays 0.
- Sample round: model returns 0x34,0x12,0xCD,0xAB,0x00,0x80 for 0x28..0x2D -> one sample_valid pulse with accel_x=16'h1234, accel_y=16'hABCD, accel_z=16'h8000; reads issued at addresses 0x28..0x2D in order, each enable one cycle wide with addr stable until done.
- Poll spacing: POLL_DIV=10 -> sample_valid pulses spaced exactly 220 cycles apart; accel_* unchanged between pulses.
- Reset mid-read: assert reset during the third RD_WAIT -> all outputs 0 next cycle; after release, the next spi_enable carries addr 0x0F with read=1; the partial buffer never appears on accel_*.
- Spurious done: pulse spi_done during POLL -> no state change, no capture; POLL duration unaffected.
